// File: rtl/banco_de_registros.sv
// Two-read / one-write register file with register 0 hard-wired to zero.
// Define BANCO_BYPASS_EN to forward same-cycle write data to the read ports.
module banco_de_registros #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] addressA,
    input  logic [ADDRESS_WIDTH-1:0] addressB,
    input  logic [ADDRESS_WIDTH-1:0] addressW,
    input  logic [DATA_WIDTH-1:0]    data,
    output logic [DATA_WIDTH-1:0]    regA,
    output logic [DATA_WIDTH-1:0]    regB
);

    localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] regFile [NUM_REGS];
    logic                  writeValid;

    // Address 0 is never stored to, so it stays at its reset value of zero.
    assign writeValid = we && (addressW != {ADDRESS_WIDTH{1'b0}});

    // Register array: synchronous clear has priority over the write port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regFile[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (writeValid) begin
            regFile[addressW] <= data;
        end
    end

`ifdef BANCO_BYPASS_EN
    logic bypassA;
    logic bypassB;

    // Forwarding is only meaningful when the write will actually land at this edge.
    assign bypassA = reset && writeValid && (addressA == addressW);
    assign bypassB = reset && writeValid && (addressB == addressW);

    // Read port A with write forwarding.
    always_comb begin
        regA = {DATA_WIDTH{1'b0}};
        if (addressA == {ADDRESS_WIDTH{1'b0}}) begin
            regA = {DATA_WIDTH{1'b0}};
        end else if (bypassA) begin
            regA = data;
        end else begin
            regA = regFile[addressA];
        end
    end

    // Read port B with write forwarding.
    always_comb begin
        regB = {DATA_WIDTH{1'b0}};
        if (addressB == {ADDRESS_WIDTH{1'b0}}) begin
            regB = {DATA_WIDTH{1'b0}};
        end else if (bypassB) begin
            regB = data;
        end else begin
            regB = regFile[addressB];
        end
    end
`else
    // Read port A, read-old: returns the pre-edge contents.
    always_comb begin
        regA = {DATA_WIDTH{1'b0}};
        if (addressA == {ADDRESS_WIDTH{1'b0}}) begin
            regA = {DATA_WIDTH{1'b0}};
        end else begin
            regA = regFile[addressA];
        end
    end

    // Read port B, read-old: returns the pre-edge contents.
    always_comb begin
        regB = {DATA_WIDTH{1'b0}};
        if (addressB == {ADDRESS_WIDTH{1'b0}}) begin
            regB = {DATA_WIDTH{1'b0}};
        end else begin
            regB = regFile[addressB];
        end
    end
`endif

endmodule

// File: tb/tb_banco_de_registros.sv
// Self-checking bench for banco_de_registros: vector table plus a scoreboard queue.
module tb_banco_de_registros;

    localparam int DW = 32;
    localparam int AW = 5;
`ifdef BANCO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          we;
    logic [AW-1:0] addressA;
    logic [AW-1:0] addressB;
    logic [AW-1:0] addressW;
    logic [DW-1:0] data;
    logic [DW-1:0] regA;
    logic [DW-1:0] regB;

    always #5 clk = ~clk;

    banco_de_registros #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .we(we),
        .addressA(addressA), .addressB(addressB), .addressW(addressW),
        .data(data), .regA(regA), .regB(regB)
    );

    typedef struct packed {
        logic          rst;
        logic          wen;
        logic [AW-1:0] aW;
        logic [AW-1:0] aA;
        logic [AW-1:0] aB;
        logic [DW-1:0] d;
        logic [DW-1:0] preA;
        logic [DW-1:0] preB;
        logic [DW-1:0] postA;
        logic [DW-1:0] postB;
    } vec_t;

    typedef struct {
        int            tag;
        logic [DW-1:0] expA;
        logic [DW-1:0] expB;
    } exp_t;

    int            testsRun = 0;
    int            testsFailed = 0;
    exp_t          sbQ[$];
    vec_t          vecs[13];
    logic [DW-1:0] model[32];

    task automatic pushExp(input int tag, input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        e.tag = tag;
        e.expA = a;
        e.expB = b;
        sbQ.push_back(e);
    endtask

    task automatic checkOut();
        exp_t e;
        if (sbQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("FAIL scoreboard empty: got nothing, required an entry");
        end else begin
            e = sbQ.pop_front();
            testsRun++;
            if (regA !== e.expA) begin
                testsFailed++;
                $display("FAIL tag%0d regA: got %h, required %h", e.tag, regA, e.expA);
            end
            testsRun++;
            if (regB !== e.expB) begin
                testsFailed++;
                $display("FAIL tag%0d regB: got %h, required %h", e.tag, regB, e.expB);
            end
        end
    endtask

    function automatic logic [DW-1:0] pattern(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b, b ^ 8'hA5, 8'h3C};
    endfunction

    initial begin
        //             rst   we    aW     aA     aB     data           preA                            preB                            postA          postB
        vecs[0]  = '{1'b0, 1'b1, 5'd2,  5'd2,  5'd3,  32'h0000000F, 32'h0,                          32'h0,                          32'h0,         32'h0};
        vecs[1]  = '{1'b1, 1'b1, 5'd2,  5'd2,  5'd3,  32'h00000008, BYP ? 32'h8 : 32'h0,            32'h0,                          32'h8,         32'h0};
        vecs[2]  = '{1'b1, 1'b0, 5'd2,  5'd2,  5'd3,  32'h00000008, 32'h8,                          32'h0,                          32'h8,         32'h0};
        vecs[3]  = '{1'b1, 1'b1, 5'd3,  5'd2,  5'd3,  32'h00000005, 32'h8,                          BYP ? 32'h5 : 32'h0,            32'h8,         32'h5};
        vecs[4]  = '{1'b1, 1'b1, 5'd0,  5'd0,  5'd3,  32'hFFFFFFFF, 32'h0,                          32'h5,                          32'h0,         32'h5};
        vecs[5]  = '{1'b1, 1'b0, 5'd3,  5'd2,  5'd3,  32'h00001234, 32'h8,                          32'h5,                          32'h8,         32'h5};
        vecs[6]  = '{1'b1, 1'b1, 5'd2,  5'd2,  5'd2,  32'h0000000A, BYP ? 32'hA : 32'h8,            BYP ? 32'hA : 32'h8,            32'hA,         32'hA};
        vecs[7]  = '{1'b1, 1'b1, 5'd31, 5'd31, 5'd2,  32'hDEADBEEF, BYP ? 32'hDEADBEEF : 32'h0,     32'hA,                          32'hDEADBEEF,  32'hA};
        vecs[8]  = '{1'b1, 1'b0, 5'd31, 5'd31, 5'd31, 32'h00000000, 32'hDEADBEEF,                   32'hDEADBEEF,                   32'hDEADBEEF,  32'hDEADBEEF};
        vecs[9]  = '{1'b1, 1'b1, 5'd5,  5'd5,  5'd3,  32'h80000001, BYP ? 32'h80000001 : 32'h0,     32'h5,                          32'h80000001,  32'h5};
        vecs[10] = '{1'b0, 1'b1, 5'd7,  5'd2,  5'd31, 32'h00000077, 32'hA,                          32'hDEADBEEF,                   32'h0,         32'h0};
        vecs[11] = '{1'b1, 1'b1, 5'd7,  5'd7,  5'd5,  32'h00000077, BYP ? 32'h77 : 32'h0,           32'h0,                          32'h77,        32'h0};
        vecs[12] = '{1'b1, 1'b1, 5'd4,  5'd7,  5'd4,  32'h00000044, 32'h77,                         BYP ? 32'h44 : 32'h0,           32'h77,        32'h44};

        reset = 1'b0; we = 1'b0; data = 32'h0;
        addressA = 5'd0; addressB = 5'd0; addressW = 5'd0;

        // Initial reset edge, then every address must read zero on both ports.
        @(negedge clk);
        reset = 1'b0; we = 1'b1; addressW = 5'd9; data = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1; we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            addressA = AW'(i);
            addressB = AW'(31 - i);
            pushExp(1000 + i, 32'h0, 32'h0);
            #1 checkOut();
        end

        // Vector table: pre-edge (combinational) and post-edge reads per vector.
        for (int v = 0; v < 13; v++) begin
            @(negedge clk);
            reset = vecs[v].rst; we = vecs[v].wen; addressW = vecs[v].aW;
            addressA = vecs[v].aA; addressB = vecs[v].aB; data = vecs[v].d;
            pushExp(v * 10, vecs[v].preA, vecs[v].preB);
            #1 checkOut();
            pushExp(v * 10 + 1, vecs[v].postA, vecs[v].postB);
            @(posedge clk);
            #1 checkOut();
        end

        // Fill every register with a distinct pattern, then read all back.
        model[0] = 32'h0;
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            reset = 1'b1; we = 1'b1; addressW = AW'(i); data = pattern(i);
            model[i] = pattern(i);
        end
        @(negedge clk);
        we = 1'b0; data = 32'h0;
        for (int i = 0; i < 32; i++) begin
            addressA = AW'(i);
            addressB = AW'(31 - i);
            pushExp(2000 + i, model[i], model[31 - i]);
            #1 checkOut();
        end

        // Mid-sequence reset clears the whole populated file.
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            addressA = AW'(i);
            addressB = AW'(i);
            pushExp(3000 + i, 32'h0, 32'h0);
            #1 checkOut();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
